// File: rtl/vec_reg_bank.sv
// vec_reg_bank: NREGS x REG_W vector register bank with a BUS_W-bit
// valid/ready load/read port. Groups wider than the bus move as several beats.
// Beat b, lane k addresses register (base + b*LPB + k) mod NREGS.
// Optional build macro VREG_MON_EN adds the flat mon_regs snapshot port.
module vec_reg_bank #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned REG_W = 32,
    parameter int unsigned BUS_W = 128,
    localparam int unsigned IW   = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [IW-1:0]          cmd_idx,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [BUS_W-1:0]       wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [BUS_W-1:0]       rd_data,
    output logic                   rd_last,
    output logic                   busy
`ifdef VREG_MON_EN
    ,
    output logic [NREGS*REG_W-1:0] mon_regs
`endif
);

    // Registers carried per beat, and the width of group-size / beat counters
    // (must hold NREGS itself, hence one bit more than the index).
    localparam int unsigned LPB = BUS_W / REG_W;
    localparam int unsigned CW  = IW + 1;

    localparam logic [2:0] OP_LOAD1   = 3'b000;
    localparam logic [2:0] OP_LOAD4   = 3'b001;
    localparam logic [2:0] OP_LOADALL = 3'b010;
    localparam logic [2:0] OP_READ4   = 3'b011;
    localparam logic [2:0] OP_READALL = 3'b100;
    localparam logic [2:0] OP_READ1   = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    // Register storage; packed so register i sits at [i*REG_W +: REG_W].
    logic [NREGS-1:0][REG_W-1:0] regs;

    logic [1:0]     state;
    logic [IW-1:0]  lat_base;
    logic [CW-1:0]  lat_grp;
    logic [CW-1:0]  lat_beats;
    logic [CW-1:0]  beat_cnt;

    // Decoded view of the command currently offered on cmd_*
    logic [CW-1:0]  cmd_grp;
    logic [IW-1:0]  cmd_base;
    logic [CW-1:0]  cmd_beats;
    logic           cmd_is_load;
    logic           cmd_is_read;
    logic           cmd_is_clear;

    logic           cmd_acc;
    logic           wr_hs;
    logic           rd_hs;
    logic           wr_final;

    // Source of the next read beat: the new command when idle, else the
    // latched group one beat further on.
    logic [IW-1:0]  src_base;
    logic [CW-1:0]  src_grp;
    logic [CW-1:0]  src_beat;
    logic [BUS_W-1:0] rd_next_data;
    logic           rd_next_last;

    logic [LPB-1:0] wr_lane_en;
    logic [IW-1:0]  wr_lane_idx [LPB];

    // Command decode: group size, effective base and beat count
    always_comb begin
        cmd_grp      = CW'(1);
        cmd_base     = cmd_idx;
        cmd_is_load  = 1'b0;
        cmd_is_read  = 1'b0;
        cmd_is_clear = 1'b0;
        case (cmd_op)
            OP_LOAD1: begin
                cmd_is_load = 1'b1;
            end
            OP_LOAD4: begin
                cmd_grp     = CW'(4);
                cmd_is_load = 1'b1;
            end
            OP_LOADALL: begin
                cmd_grp     = CW'(NREGS);
                cmd_base    = '0;
                cmd_is_load = 1'b1;
            end
            OP_READ4: begin
                cmd_grp     = CW'(4);
                cmd_is_read = 1'b1;
            end
            OP_READALL: begin
                cmd_grp     = CW'(NREGS);
                cmd_base    = '0;
                cmd_is_read = 1'b1;
            end
            OP_READ1: begin
                cmd_is_read = 1'b1;
            end
            OP_CLEAR: begin
                cmd_is_clear = 1'b1;
            end
            default: begin
            end
        endcase
        cmd_beats = CW'((32'(cmd_grp) + LPB - 1) / LPB);
    end

    // Handshake qualifiers
    always_comb begin
        cmd_acc  = cmd_valid && (state == ST_IDLE);
        wr_hs    = wr_valid && (state == ST_WRITE);
        rd_hs    = rd_ready && (state == ST_READ);
        wr_final = wr_hs && (beat_cnt == lat_beats - CW'(1));
    end

    // Assemble the next read beat; lanes past the group end read as zero
    always_comb begin
        int unsigned pos;
        pos = 0;
        if (state == ST_IDLE) begin
            src_base     = cmd_base;
            src_grp      = cmd_grp;
            src_beat     = '0;
            rd_next_last = (cmd_beats == CW'(1));
        end else begin
            src_base     = lat_base;
            src_grp      = lat_grp;
            src_beat     = beat_cnt + CW'(1);
            rd_next_last = (beat_cnt + CW'(2) == lat_beats);
        end
        rd_next_data = '0;
        for (int unsigned k = 0; k < LPB; k++) begin
            pos = 32'(src_beat) * LPB + k;
            if (pos < 32'(src_grp)) begin
                rd_next_data[k*REG_W +: REG_W] = regs[src_base + IW'(pos)];
            end
        end
    end

    // Per-lane target register and enable for the current write beat
    always_comb begin
        int unsigned pos;
        pos = 0;
        wr_lane_en = '0;
        for (int unsigned k = 0; k < LPB; k++) begin
            pos            = 32'(beat_cnt) * LPB + k;
            wr_lane_idx[k] = lat_base + IW'(pos);
            wr_lane_en[k]  = (pos < 32'(lat_grp));
        end
    end

    // Control FSM: latch the command, count beats, register read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            lat_base  <= '0;
            lat_grp   <= '0;
            lat_beats <= '0;
            beat_cnt  <= '0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_acc) begin
                        lat_base  <= cmd_base;
                        lat_grp   <= cmd_grp;
                        lat_beats <= cmd_beats;
                        beat_cnt  <= '0;
                        if (cmd_is_load) begin
                            state <= ST_WRITE;
                        end else if (cmd_is_read) begin
                            state   <= ST_READ;
                            rd_data <= rd_next_data;
                            rd_last <= rd_next_last;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_hs) begin
                        if (wr_final) begin
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                ST_READ: begin
                    if (rd_hs) begin
                        if (rd_last) begin
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                            rd_data  <= '0;
                            rd_last  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                            rd_data  <= rd_next_data;
                            rd_last  <= rd_next_last;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register file: reset/CLEAR zero everything, write beats update lanes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (cmd_acc && cmd_is_clear) begin
            regs <= '0;
        end else if (wr_hs) begin
            for (int unsigned k = 0; k < LPB; k++) begin
                if (wr_lane_en[k]) begin
                    regs[wr_lane_idx[k]] <= wr_data[k*REG_W +: REG_W];
                end
            end
        end
    end

    // Handshake outputs follow the registered state
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        wr_ready  = (state == ST_WRITE);
        rd_valid  = (state == ST_READ);
        busy      = (state != ST_IDLE);
    end

`ifdef VREG_MON_EN
    // Zero-lag snapshot of the bank, forced to zero while reset is asserted
    always_comb begin
        mon_regs = reset ? '0 : regs;
    end
`endif

endmodule

// File: tb/tb_vec_reg_bank.sv
// tb_vec_reg_bank: directed plus randomized checks of vec_reg_bank
// (default 16x32 bank, 128-bit bus) against an array-based reference model.
module tb_vec_reg_bank;

    localparam int NREGS = 16;
    localparam int REG_W = 32;
    localparam int BUS_W = 128;
    localparam int LPB   = BUS_W / REG_W;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_idx;
    logic             wr_valid;
    logic             wr_ready;
    logic [BUS_W-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [BUS_W-1:0] rd_data;
    logic             rd_last;
    logic             busy;

    int tests = 0;
    int fails = 0;

    // Reference model: register contents, plus the data words a load sends,
    // indexed by running position within the group.
    logic [31:0] mdl [NREGS];
    logic [31:0] src [NREGS];

    vec_reg_bank #(
        .NREGS(NREGS),
        .REG_W(REG_W),
        .BUS_W(BUS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int grp_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd5: return 1;
            3'd1, 3'd3: return 4;
            3'd2, 3'd4: return NREGS;
            default:    return 0;
        endcase
    endfunction

    function automatic int base_of(input logic [2:0] op, input logic [3:0] idx);
        return (op == 3'd2 || op == 3'd4) ? 0 : int'(idx);
    endfunction

    function automatic logic [BUS_W-1:0] exp_beat(input int b, input int g, input int base);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int k = 0; k < LPB; k++) begin
            int pos;
            pos = b * LPB + k;
            if (pos < g) r[k*REG_W +: REG_W] = mdl[(base + pos) % NREGS];
        end
        return r;
    endfunction

    task automatic clear_model;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    endtask

    // Offer one command for exactly one cycle; cmd_* turn to junk afterwards
    task automatic issue(input logic [2:0] op, input logic [3:0] idx);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        wr_valid  = 1'($urandom % 2);
        wr_data   = {$urandom, $urandom, $urandom, $urandom};
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        tick;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_idx   = 4'($urandom);
        wr_valid  = 1'b0;
    endtask

    // mode 0: wr_valid held high, 1: every other cycle, 2: random
    task automatic do_load(input logic [2:0] op, input logic [3:0] idx, input int mode);
        int g, base, nb, b, cyc;
        logic v;
        g    = grp_of(op);
        base = base_of(op, idx);
        nb   = (g + LPB - 1) / LPB;
        issue(op, idx);
        b   = 0;
        cyc = 0;
        while (b < nb && cyc < 200) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom % 2);
            wr_valid = v;
            for (int k = 0; k < LPB; k++) begin
                int pos;
                pos = b * LPB + k;
                wr_data[k*REG_W +: REG_W] = (pos < g) ? src[pos] : $urandom;
            end
            check("load_wr_ready", wr_ready, 1'b1);
            check("load_cmd_ready_low", cmd_ready, 1'b0);
            check("load_busy", busy, 1'b1);
            tick;
            if (v) b++;
            cyc++;
        end
        wr_valid = 1'b0;
        check("load_beats_done", b, nb);
        for (int p = 0; p < g; p++) mdl[(base + p) % NREGS] = src[p];
        check("load_end_wr_ready", wr_ready, 1'b0);
        check("load_end_cmd_ready", cmd_ready, 1'b1);
        check("load_end_busy", busy, 1'b0);
    endtask

    // mode 0: rd_ready held high, 1: pattern 1,0,0,1,1,0,1, 2: random
    task automatic do_read(input logic [2:0] op, input logic [3:0] idx, input int mode);
        int g, base, nb, b, cyc;
        logic r;
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        g    = grp_of(op);
        base = base_of(op, idx);
        nb   = (g + LPB - 1) / LPB;
        issue(op, idx);
        b   = 0;
        cyc = 0;
        while (b < nb && cyc < 200) begin
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = pat[cyc % 7];
            else                r = 1'($urandom % 2);
            rd_ready = r;
            wr_valid = 1'($urandom % 2);
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            check("read_rd_valid", rd_valid, 1'b1);
            check("read_rd_data", rd_data, exp_beat(b, g, base));
            check("read_rd_last", rd_last, (b == nb - 1));
            tick;
            if (r) b++;
            cyc++;
        end
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        check("read_beats_done", b, nb);
        check("read_end_rd_valid", rd_valid, 1'b0);
        check("read_end_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_wr_ready"}, wr_ready, 1'b0);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_rd_data"}, rd_data, '0);
        check({tag, "_rd_last"}, rd_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [2:0] op;
        logic [3:0] idx;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_idx   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        clear_model();
        repeat (2) tick;
        check_idle_outputs("reset");
        reset = 1'b0;
        tick;
        do_read(3'd4, 4'd0, 0);

        // LOAD1 idx 5
        src[0] = 32'hDEADBEEF;
        do_load(3'd0, 4'd5, 0);
        do_read(3'd4, 4'd0, 0);

        // LOAD4 idx 14 wraps to registers 0 and 1
        src[0] = 32'h1; src[1] = 32'h2; src[2] = 32'h3; src[3] = 32'h4;
        do_load(3'd1, 4'd14, 0);
        do_read(3'd3, 4'd14, 0);

        // LOADALL with gapped wr_valid, READALL with stalling rd_ready
        for (int i = 0; i < NREGS; i++) src[i] = 32'h100 + 32'(i);
        do_load(3'd2, 4'd9, 1);
        do_read(3'd4, 4'd7, 1);

        // READ1 idx 3, then CLEAR
        src[0] = 32'hA5A5A5A5;
        do_load(3'd0, 4'd3, 0);
        do_read(3'd5, 4'd3, 0);
        check("pre_clear_busy", busy, 1'b0);
        issue(3'd6, 4'd0);
        clear_model();
        check("clear_busy", busy, 1'b0);
        check("clear_cmd_ready", cmd_ready, 1'b1);
        do_read(3'd4, 4'd0, 0);

        // Reset after 2 of 4 LOADALL beats
        for (int i = 0; i < NREGS; i++) src[i] = $urandom;
        do_load(3'd2, 4'd0, 0);
        issue(3'd2, 4'd0);
        for (int b = 0; b < 2; b++) begin
            wr_valid = 1'b1;
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            tick;
        end
        check("midload_busy", busy, 1'b1);
        reset    = 1'b1;
        wr_valid = 1'b0;
        #2;
        check_idle_outputs("midload_reset");
        tick;
        reset = 1'b0;
        clear_model();
        check_idle_outputs("after_reset");
        src[0] = $urandom;
        do_load(3'd0, 4'($urandom), 0);
        do_read(3'd4, 4'd0, 0);

        // Randomized command stream
        for (int n = 0; n < 60; n++) begin
            op  = 3'($urandom_range(0, 7));
            idx = 4'($urandom);
            for (int i = 0; i < NREGS; i++) src[i] = $urandom;
            case (op)
                3'd0, 3'd1, 3'd2: do_load(op, idx, 2);
                3'd3, 3'd4, 3'd5: do_read(op, idx, 2);
                3'd6: begin
                    issue(op, idx);
                    clear_model();
                    check("rand_clear_busy", busy, 1'b0);
                end
                default: begin
                    issue(op, idx);
                    check("rand_nop_busy", busy, 1'b0);
                end
            endcase
            repeat ($urandom_range(0, 2)) tick;
        end
        do_read(3'd4, 4'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vec_reg_bank.md
# vec_reg_bank

Parametrised vector register bank for the neuromorphic datapath. It generalises the weight and spike vector registers into one configurable bank: NREGS registers of REG_W bits, loaded and read over a BUS_W-bit port. It uses valid/ready handshakes and multi-beat transfers when a register group is wider than the bus. One instance serves as the weight bank and another as the spike bank, feeding the neuron accumulator.

## Interface
- NREGS, 16, number of registers; power of two, at least 4.
- REG_W, 32, bits per register.
- BUS_W, 128, data bus width; a multiple of REG_W and no more than NREGS*REG_W. LPB = BUS_W/REG_W is the number of registers per beat.
- IW, $clog2(NREGS), index width (localparam).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  bank can accept a command.
- cmd_op  in  3  operation code.
- cmd_idx  in  IW  base register index.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  bank accepts a write beat.
- wr_data  in  BUS_W  write beat; lane k is bits [k*REG_W +: REG_W].
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  consumer accepts the read beat.
- rd_data  out  BUS_W  read beat, same lane layout as wr_data.
- rd_last  out  1  marks the final beat of a read.
- busy  out  1  high whenever the FSM is not IDLE.
- mon_regs  out  NREGS*REG_W  flat snapshot; register i is at [i*REG_W +: REG_W]. Present only with VREG_MON_EN.

## Operation
- Opcodes and group size G:
  - 000 LOAD1, G=1.
  - 001 LOAD4, G=4.
  - 010 LOADALL, G=NREGS.
  - 011 READ4, G=4.
  - 100 READALL, G=NREGS.
  - 101 READ1, G=1.
  - 110 CLEAR.
  - 111 NOP.
- Beats per command = ceil(G/LPB). Beat b, lane k addresses register (base + b*LPB + k) mod NREGS. For READALL and LOADALL the base is forced to 0.
- Lanes whose running position is G or more are unused. On writes they are ignored. On reads they are driven to 0.
- FSM states:
  - IDLE: cmd_ready=1. A command is accepted on cmd_valid && cmd_ready.
  - A LOAD goes to WRITE. A READ goes to READ. CLEAR zeroes all registers at the accept edge and stays in IDLE. NOP stays in IDLE.
  - Opcode, base and beat count are latched at the accept edge; later changes on cmd_* are ignored.
  - WRITE: wr_ready=1. Each wr_valid && wr_ready writes one beat and increments the beat counter. The final beat returns the FSM to IDLE. wr_valid low simply stalls.
  - READ: rd_valid=1. rd_data and rd_last are registered and hold stable while rd_ready=0. Each rd_valid && rd_ready loads the next beat. The handshake on the rd_last beat returns the FSM to IDLE.
- Outside WRITE, wr_ready=0 and wr_* are ignored.
- The bank has a single port, so no concurrent read/write hazard exists.
- Index arithmetic is IW-bit unsigned and wraps modulo NREGS.

## Timing
- Reset values:
  - All registers 0, state IDLE.
  - cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, rd_last=0, busy=0.
- Reset mid-operation aborts immediately. Partially loaded registers also return to 0.
- Command accepted at edge N:
  - Read: rd_valid is high in the cycle after edge N, carrying beat 0.
  - Load: wr_ready is high in the cycle after edge N.
- Throughput is one beat per cycle when wr_valid or rd_ready is held high.
- A write beat updates registers at its handshake edge.
- cmd_ready is high again in the cycle after the final beat's handshake. There is no back-to-back command in the same cycle as a final beat.
- CLEAR and NOP occupy only the accept cycle.

## Configuration
- VREG_MON_EN:
  - Defined: mon_regs is present, driven combinationally from the bank with zero lag, and reads 0 during reset.
  - Undefined: the port is absent and there is no monitoring logic.
- Command behaviour is identical in both builds.

## Test plan
All scenarios use the defaults (16/32/128).
- LOAD1 idx 5, lane0=0xDEADBEEF, one write beat -> reg5=0xDEADBEEF, all other registers 0, wr_ready low in the next cycle, cmd_ready high.
- LOAD4 idx 14, lanes {0x4,0x3,0x2,0x1} (lane3..lane0) -> reg14=1, reg15=2, reg0=3, reg1=4 (wrap-around). READ4 idx 14 then returns the same beat with rd_last=1.
- LOADALL, wr_valid gapped every other cycle, beat b lanes = 0x100+4b+k -> reg i = 0x100+i. cmd_ready stays 0 until the cycle after the 4th handshake.
- READALL with rd_ready pattern 1,0,0,1,1,0,1 -> 4 beats in order, rd_data and rd_last stable through stalls, rd_last high only on beat 3.
- READ1 idx 3 with reg3=0xA5A5A5A5 -> rd_data={96'b0,0xA5A5A5A5}, rd_last=1, one beat. A CLEAR then zeroes all registers in one cycle, with busy staying 0.
- Reset asserted after 2 of 4 LOADALL beats -> all registers 0, state IDLE, rd_valid=0, wr_ready=0. A following LOAD1 completes normally.
